render_scheduler: RTL

RENDER_SCHEDULER -- requirements
Module: render_scheduler

---
 rtl/render_scheduler_pkg.sv | 25 ++
 rtl/render_scheduler_pixel_coord_counter.sv | 49 ++++
 rtl/render_scheduler.sv | 134 +++++++++++++
 3 files changed

// File: rtl/render_scheduler_pkg.sv
// render_scheduler_pkg
// Shared render definitions: ray-core state encoding, scheduler FSM states,
// default framebuffer geometry and the screen-coordinate width.
package render_scheduler_pkg;

    localparam int unsigned FRAMEBUFFER_WIDTH  = 320;
    localparam int unsigned FRAMEBUFFER_HEIGHT = 240;
    localparam int unsigned SCREEN_COORD       = 11;

    typedef enum logic [2:0] {
        RCS_Init     = 3'd0,
        RCS_SetupRay = 3'd1,
        RCS_Traverse = 3'd2,
        RCS_Shade    = 3'd3,
        RCS_Done     = 3'd4
    } RayCoreState;

    typedef enum logic [1:0] {
        SCHED_INIT       = 2'd0,
        SCHED_RENDER     = 2'd1,
        SCHED_STEP       = 2'd2,
        SCHED_WAIT_VSYNC = 2'd3
    } SchedState;

endpackage

// File: rtl/render_scheduler_pixel_coord_counter.sv
// pixel_coord_counter
// Raster-order x/y pixel position with row wrap and a last-pixel flag.
// Ports:
//   clk, reset  - rising-edge clock, synchronous active-high reset
//   clear       - load (0,0) for the first pixel of a frame
//   advance     - step to the next pixel in raster order
//   x, y        - registered current pixel coordinate
//   lastPixel   - high while (x,y) is the final pixel of the frame
module pixel_coord_counter
    import render_scheduler_pkg::*;
#(
    parameter int unsigned FB_WIDTH  = FRAMEBUFFER_WIDTH,
    parameter int unsigned FB_HEIGHT = FRAMEBUFFER_HEIGHT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clear,
    input  logic                    advance,
    output logic [SCREEN_COORD-1:0] x,
    output logic [SCREEN_COORD-1:0] y,
    output logic                    lastPixel
);

    localparam logic [SCREEN_COORD-1:0] X_LAST    = SCREEN_COORD'(FB_WIDTH - 1);
    localparam logic [SCREEN_COORD-1:0] Y_LAST    = SCREEN_COORD'(FB_HEIGHT - 1);
    localparam logic [SCREEN_COORD-1:0] COORD_ONE = SCREEN_COORD'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            x <= '0;
            y <= '0;
        end else if (clear) begin
            x <= '0;
            y <= '0;
        end else if (advance) begin
            if (x < X_LAST) begin
                x <= x + COORD_ONE;
            end else begin
                x <= '0;
                y <= y + COORD_ONE;
            end
        end
    end

    always_comb begin
        lastPixel = (x == X_LAST) && (y == Y_LAST);
    end

endmodule

// File: rtl/render_scheduler.sv
// render_scheduler
// Walks the framebuffer in raster order, issuing one pixel at a time to the
// ray core and waiting for it to finish before issuing the next. New frames
// start from reset/idle, or after a fresh vsync falling edge once a frame
// has completed (at most one frame per blanking interval).
// Ports:
//   clk, reset   - rising-edge clock, synchronous active-high reset
//   enable       - permits frame starts (ignored once a frame is running)
//   vsync        - display sync, 0 = blanking
//   core_state   - current ray-core state
//   strobe       - one-cycle pixel start pulse to the ray core
//   x, y         - pixel coordinate, held until the next strobe
//   frame_start  - pulse with the first strobe of a frame
//   frame_flip   - front/back buffer select, toggles on each vsync restart
//   frame_done   - pulse after the last pixel of a frame completes
//   frame_count  - completed frames, wraps 31->0
module render_scheduler
    import render_scheduler_pkg::*;
#(
    parameter int unsigned FB_WIDTH  = FRAMEBUFFER_WIDTH,
    parameter int unsigned FB_HEIGHT = FRAMEBUFFER_HEIGHT
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    vsync,
    input  RayCoreState             core_state,
    output logic                    strobe,
    output logic [SCREEN_COORD-1:0] x,
    output logic [SCREEN_COORD-1:0] y,
    output logic                    frame_start,
    output logic                    frame_flip,
    output logic                    frame_done,
    output logic [4:0]              frame_count
);

    SchedState state;
    logic      busySeen;
    logic      vsyncArmed;
    logic      vsyncQ;
    logic      lastPixel;
    logic      frameGo;
    logic      coordAdvance;

    pixel_coord_counter #(
        .FB_WIDTH (FB_WIDTH),
        .FB_HEIGHT(FB_HEIGHT)
    ) coordCounter (
        .clk      (clk),
        .reset    (reset),
        .clear    (frameGo),
        .advance  (coordAdvance),
        .x        (x),
        .y        (y),
        .lastPixel(lastPixel)
    );

    // Frame start condition; shared by the FSM and the coordinate clear.
    always_comb begin
        frameGo = 1'b0;
        case (state)
            SCHED_INIT:       frameGo = enable && (core_state == RCS_Init);
            SCHED_WAIT_VSYNC: frameGo = vsyncArmed && !vsync && enable &&
                                        (core_state == RCS_Init);
            default:          frameGo = 1'b0;
        endcase
        coordAdvance = (state == SCHED_STEP) && !lastPixel;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= SCHED_INIT;
            strobe      <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            frame_flip  <= 1'b0;
            frame_count <= '0;
            busySeen    <= 1'b0;
            vsyncArmed  <= 1'b0;
            vsyncQ      <= 1'b1;
        end else begin
            strobe      <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            vsyncQ      <= vsync;
            case (state)
                SCHED_INIT: begin
                    if (frameGo) begin
                        strobe      <= 1'b1;
                        frame_start <= 1'b1;
                        busySeen    <= 1'b0;
                        state       <= SCHED_RENDER;
                    end
                end
                SCHED_RENDER: begin
                    // A Done is only accepted after the core has been seen
                    // busy, so a Done left over from the previous pixel is
                    // never mistaken for completion of the current one.
                    if (core_state != RCS_Done) begin
                        busySeen <= 1'b1;
                    end else if (busySeen) begin
                        state <= SCHED_STEP;
                    end
                end
                SCHED_STEP: begin
                    if (lastPixel) begin
                        frame_done  <= 1'b1;
                        frame_count <= frame_count + 5'd1;
                        vsyncArmed  <= 1'b0;
                        state       <= SCHED_WAIT_VSYNC;
                    end else begin
                        strobe   <= 1'b1;
                        busySeen <= 1'b0;
                        state    <= SCHED_RENDER;
                    end
                end
                SCHED_WAIT_VSYNC: begin
                    if (vsyncQ && !vsync) begin
                        vsyncArmed <= 1'b1;
                    end
                    if (frameGo) begin
                        frame_flip  <= ~frame_flip;
                        strobe      <= 1'b1;
                        frame_start <= 1'b1;
                        busySeen    <= 1'b0;
                        state       <= SCHED_RENDER;
                    end
                end
                default: state <= SCHED_INIT;
            endcase
        end
    end

endmodule
